// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_pkg
// Brief   : JK command encoding ({J,K}) and the single-bit next-state function.
// Rev     : 1.0  initial release
// ============================================================================
package jk_pkg;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        case (jk)
            HOLD:    return q;
            RESET:   return 1'b0;
            SET:     return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module  : jk_mod_counter_if
// Brief   : Control/observation bundle of jk_mod_counter.
//           JK_MOD_COUNTER_WRAP_FLAG_EN adds wrap_clr / wrapped.
// Rev     : 1.0  initial release
// ============================================================================
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
`ifdef JK_MOD_COUNTER_WRAP_FLAG_EN
    logic             wrap_clr;
    logic             wrapped;

    modport master (
        output en, up, load, load_val, wrap_clr,
        input  q, qb, tc, j_out, k_out, wrapped
    );
    modport slave (
        input  en, up, load, load_val, wrap_clr,
        output q, qb, tc, j_out, k_out, wrapped
    );
`else
    modport master (
        output en, up, load, load_val,
        input  q, qb, tc, j_out, k_out
    );
    modport slave (
        input  en, up, load, load_val,
        output q, qb, tc, j_out, k_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/jk_stage.sv
`default_nettype none
// ============================================================================
// Module  : jk_stage
// Brief   : Single-bit JK flip-flop with asynchronous active-low clear.
// Rev     : 1.0  initial release
// ============================================================================
module jk_stage
    import jk_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic j,
    input  wire logic k,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, {j, k});
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : jk_mod_counter
// Brief   : Modulo-MODULUS up/down counter built from WIDTH JK stages.
//           JK_MOD_COUNTER_WRAP_FLAG_EN adds a sticky wrap flag.
// Rev     : 1.0  initial release
// ============================================================================
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    jk_mod_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_load_l;
    logic [WIDTH-1:0] w_tog_up;
    logic [WIDTH-1:0] w_tog_dn;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_up;
    logic             w_wrap_dn;

    assign w_at_max  = (w_q == c_max);
    assign w_at_zero = (w_q == '0);
    assign w_load_l  = (bus.load_val > c_max) ? c_max : bus.load_val;
    assign w_wrap_up = bus.en & ~bus.load &  bus.up & w_at_max;
    assign w_wrap_dn = bus.en & ~bus.load & ~bus.up & w_at_zero;

    // Binary ripple toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
    assign w_tog_up[0] = 1'b1;
    assign w_tog_dn[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign w_tog_up[i] =  &w_q[i-1:0];
        assign w_tog_dn[i] = ~|w_q[i-1:0];
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (bus.load) begin
            w_j = w_load_l;
            w_k = ~w_load_l;
        end else if (w_wrap_up) begin
            w_j = '0;
            w_k = '1;
        end else if (w_wrap_dn) begin
            w_j = c_max;
            w_k = c_max;
        end else if (bus.en && bus.up) begin
            w_j = w_tog_up;
            w_k = w_tog_up;
        end else if (bus.en) begin
            w_j = w_tog_dn;
            w_k = w_tog_dn;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (w_j[i]),
            .k     (w_k[i]),
            .q     (w_q[i])
        );
    end

    assign bus.q     = w_q;
    assign bus.qb    = ~w_q;
    assign bus.tc    = w_wrap_up | w_wrap_dn;
    assign bus.j_out = w_j;
    assign bus.k_out = w_k;

`ifdef JK_MOD_COUNTER_WRAP_FLAG_EN
    logic r_wrapped;

    // A wrap on the same edge as a clear request keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrapped <= 1'b0;
        end else if (w_wrap_up || w_wrap_dn) begin
            r_wrapped <= 1'b1;
        end else if (bus.wrap_clr) begin
            r_wrapped <= 1'b0;
        end
    end

    assign bus.wrapped = r_wrapped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_jk_mod_counter
// Brief   : Self-checking bench for jk_mod_counter at MODULUS=10 and 16.
// Rev     : 1.0  initial release
// ============================================================================
module tb_jk_mod_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_mod_counter_if #(.WIDTH(4)) bus10 ();
    jk_mod_counter_if #(.WIDTH(4)) bus16 ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10.slave)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mq[2]   = '{0, 0};
    int mw[2]   = '{0, 0};
    int mm[2]   = '{10, 16};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit en, input bit up, input bit ld,
                         input int lv, input bit clr);
        logic [3:0] v;
        v = lv[3:0];
        bus10.en = s ? 1'b0 : en;  bus10.up = up;  bus10.load = s ? 1'b0 : ld;  bus10.load_val = v;
        bus16.en = s ? en : 1'b0;  bus16.up = up;  bus16.load = s ? ld : 1'b0;  bus16.load_val = v;
`ifdef JK_MOD_COUNTER_WRAP_FLAG_EN
        bus10.wrap_clr = s ? 1'b0 : clr;
        bus16.wrap_clr = s ? clr : 1'b0;
`else
        if (clr) begin end
`endif
    endtask

    // One clock of stimulus on counter s, checked against the arithmetic model.
    task automatic step(input bit s, input bit en, input bit up, input bit ld,
                        input int lv, input bit clr);
        int m, q, l, nq, ej, ek;
        bit etc;
        m = mm[s];
        q = mq[s];
        l = (lv > m - 1) ? m - 1 : lv;
        drive(s, en, up, ld, lv, clr);
        #1;
        etc = en && !ld && ((up && q == m - 1) || (!up && q == 0));
        if (ld)      nq = l;
        else if (!en) nq = q;
        else if (up) nq = (q + 1) % m;
        else         nq = (q + m - 1) % m;
        if (ld) begin
            ej = l;  ek = ~l & 15;
        end else if (!en) begin
            ej = 0;  ek = 0;
        end else if (up && q == m - 1) begin
            ej = 0;  ek = 15;
        end else begin
            ej = q ^ nq;  ek = ej;
        end
        chk($sformatf("tc[m%0d q%0d]", m, q), s ? bus16.tc : bus10.tc, etc);
        chk($sformatf("j_out[m%0d q%0d]", m, q), s ? bus16.j_out : bus10.j_out, ej);
        chk($sformatf("k_out[m%0d q%0d]", m, q), s ? bus16.k_out : bus10.k_out, ek);
        @(posedge clk);
        mq[s] = nq;
        mw[s] = etc ? 1 : (clr ? 0 : mw[s]);
        @(negedge clk);
        chk($sformatf("q[m%0d]", m), s ? bus16.q : bus10.q, nq);
        chk($sformatf("qb[m%0d]", m), s ? bus16.qb : bus10.qb, ~nq & 15);
`ifdef JK_MOD_COUNTER_WRAP_FLAG_EN
        chk($sformatf("wrapped[m%0d]", m), s ? bus16.wrapped : bus10.wrapped, mw[s]);
        chk("wrapped[idle]", s ? bus10.wrapped : bus16.wrapped, mw[~s]);
`endif
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset q", bus10.q, 4'h0);
        chk("reset qb", bus10.qb, 4'hF);
        chk("reset tc down", bus10.tc, 1'b1);
        chk("reset q16", bus16.q, 4'h0);
`ifdef JK_MOD_COUNTER_WRAP_FLAG_EN
        chk("reset wrapped", bus10.wrapped, 1'b0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        step(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        step(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 13, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 15, 1'b0);

        step(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        chk("async reset q", bus10.q, 4'h0);
        chk("async reset qb", bus10.qb, 4'hF);
        mq[0] = 0;  mq[1] = 0;  mw[0] = 0;  mw[1] = 0;
        @(negedge clk);
        chk("reset held q", bus10.q, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
